hd63701_intc: RTL and testbench
===============================

HD63701_INTC -- requirements
Module: hd63701_intc

Interrupt request front-end that drives the sequencer's NMI/IRQ/IRQ2_TIM/IRQ2_SCI request inputs and retires requests on vector fetch.

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is named CLK and the reset port is named RST.
REQ-002 CLK  in  1  system clock; all state changes on the rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 NMI_N  in  1  asynchronous NMI pin, active-low, falling-edge sensitive.
REQ-005 IRQ1_N  in  1  asynchronous external IRQ pin, active-low, level sensitive.
REQ-006 TIM_ICF, TIM_OCF, TIM_TOF  in  1 each  timer flag levels from the timer block.
REQ-007 TIM_EICI, TIM_EOCI, TIM_ETOI  in  1 each  timer interrupt enables.
REQ-008 SCI_IRQ  in  1  SCI request level, already gated by the SCI enables.
REQ-009 VFETCH  in  1  one-cycle strobe, asserted while the CPU reads a vector.
REQ-010 VADDR  in  8  low byte of the vector address during VFETCH ($F0-$FE).
REQ-011 OVR_CLR  in  1  one-cycle strobe that clears NMI_OVR.
REQ-012 NMI  out  1  NMI request to the sequencer (pending latch).
REQ-013 IRQ  out  1  external IRQ request to the sequencer.
REQ-014 IRQ2_TIM  out  1  timer request to the sequencer (vector $F4).
REQ-015 IRQ2_SCI  out  1  SCI request to the sequencer (vector $F0).
REQ-016 WAKE  out  1  OR of NMI, IRQ, IRQ2_TIM and IRQ2_SCI, for SLEEP/WAI exit.
REQ-017 NMI_OVR  out  1  sticky flag: an NMI edge arrived while NMI was already pending.

Function
REQ-018 NMI_N and IRQ1_N SHALL each pass through a 2-flop synchronizer (s1, s2); NMI_N SHALL have a third history flop s3.
REQ-019 The NMI edge event SHALL be defined as s3=1 and s2=0.
REQ-020 An NMI edge event SHALL set the NMI pending latch on the next rising edge.
- Total latency: NMI rises 3 clocks after NMI_N is first sampled low.
REQ-021 The NMI pending latch SHALL clear on the edge where VFETCH=1 and VADDR=$FC.
- VFETCH with any other VADDR SHALL NOT clear it.
REQ-022 A simultaneous NMI edge event and $FC fetch SHALL leave NMI pending (set wins) and SHALL NOT set NMI_OVR.
REQ-023 An NMI edge event while pending and without a $FC fetch SHALL keep one pending request (no queueing) and set NMI_OVR.
REQ-024 NMI_OVR SHALL clear on OVR_CLR; if OVR_CLR coincides with a new overrun, set wins.
REQ-025 NMI_N held low continuously SHALL produce exactly one NMI request; a new request requires high for at least 2 clocks, then low.
REQ-026 IRQ SHALL be registered from the inverted s2 of IRQ1_N: level, not latched, and not cleared by VFETCH.
- Latency: 3 clocks from pin to output.
- IRQ SHALL deassert 3 clocks after the pin returns high.
REQ-027 IRQ2_TIM SHALL equal, registered one clock after the inputs: (ICF&EICI)|(OCF&EOCI)|(TOF&ETOI).
REQ-028 IRQ2_SCI SHALL be SCI_IRQ registered one clock; flag clearing is the source block's job.
REQ-029 The block SHALL NOT apply CPU I-mask or priority; masking and priority (NMI>IRQ>TIM>SCI) belong to the sequencer.
- All four outputs MAY be high together.
REQ-030 WAKE SHALL be combinational from the four registered outputs.

Reset
REQ-031 While RST=1 at a rising edge:
- s1, s2 and s3 of both synchronizers SHALL load 1 (inactive).
- NMI, IRQ, IRQ2_TIM, IRQ2_SCI, NMI_OVR and WAKE SHALL be 0.
REQ-032 An NMI_N already low when RST deasserts SHALL NOT generate a request until it has gone high and then low again.
REQ-033 RST asserted with NMI pending SHALL drop the request; a falling edge in flight in the synchronizer SHALL be discarded.

Verification
REQ-034 NMI_N 1->0 at cycle 0, no VFETCH -> NMI=1 from cycle 3 and stays 1; VFETCH with VADDR=$FC at cycle 10 -> NMI=0 at cycle 11.
REQ-035 NMI pending, VFETCH with VADDR=$F8 -> NMI stays 1; second NMI_N edge -> NMI_OVR=1; OVR_CLR -> NMI_OVR=0 next cycle.
REQ-036 NMI edge event in the same cycle as a $FC fetch -> NMI=1 afterwards and NMI_OVR=0.
REQ-037 TIM_OCF=1 with TIM_EOCI=0 -> IRQ2_TIM=0; set TIM_EOCI=1 -> IRQ2_TIM=1 one cycle later; TIM_OCF=0 -> IRQ2_TIM=0 one cycle later; WAKE tracks it.
REQ-038 NMI_N held low through RST and after it -> NMI stays 0; raise NMI_N for 2 cycles, then lower it -> NMI=1 three cycles later.
REQ-039 IRQ1_N low for 5 cycles -> IRQ high for exactly 5 cycles, delayed by 3; VFETCH with VADDR=$F8 meanwhile does not shorten it.

Source files
------------

// File: rtl/hd63701_intc_if.sv
// Request/acknowledge signal bundle between the HD63701 interrupt front-end
// and its surroundings (pins, timer, SCI, sequencer).
interface hd63701_intc_if;
   logic       NMI_N;
   logic       IRQ1_N;
   logic       TIM_ICF;
   logic       TIM_OCF;
   logic       TIM_TOF;
   logic       TIM_EICI;
   logic       TIM_EOCI;
   logic       TIM_ETOI;
   logic       SCI_IRQ;
   logic       VFETCH;
   logic [7:0] VADDR;
   logic       OVR_CLR;
   logic       NMI;
   logic       IRQ;
   logic       IRQ2_TIM;
   logic       IRQ2_SCI;
   logic       WAKE;
   logic       NMI_OVR;

   modport slave (
      input  NMI_N, IRQ1_N,
      input  TIM_ICF, TIM_OCF, TIM_TOF, TIM_EICI, TIM_EOCI, TIM_ETOI,
      input  SCI_IRQ, VFETCH, VADDR, OVR_CLR,
      output NMI, IRQ, IRQ2_TIM, IRQ2_SCI, WAKE, NMI_OVR
   );

   modport master (
      output NMI_N, IRQ1_N,
      output TIM_ICF, TIM_OCF, TIM_TOF, TIM_EICI, TIM_EOCI, TIM_ETOI,
      output SCI_IRQ, VFETCH, VADDR, OVR_CLR,
      input  NMI, IRQ, IRQ2_TIM, IRQ2_SCI, WAKE, NMI_OVR
   );
endinterface

// File: rtl/hd63701_intc.sv
// HD63701 interrupt request front-end: pin synchronizers, NMI edge latch with
// overrun flag, level IRQ / timer / SCI requests, NMI retired on its vector fetch.
module hd63701_intc (
   input  logic          CLK,
   input  logic          RST,
   hd63701_intc_if.slave bus
);
   localparam int unsigned          VADDR_W = 8;
   localparam logic [VADDR_W-1:0]   VEC_NMI = VADDR_W'(8'hFC);

   logic       r_nmi_s1;
   logic       r_nmi_s2;
   logic       r_nmi_s3;
   logic       r_irq_s1;
   logic       r_irq_s2;
   logic [1:0] r_live;
   logic       r_nmi_arm;
   logic       r_nmi;
   logic       r_nmi_ovr;
   logic       r_irq;
   logic       r_irq2_tim;
   logic       r_irq2_sci;

   logic       w_nmi_ack;
   logic       w_nmi_edge;
   logic       w_arm_next;
   logic       w_nmi_next;
   logic       w_ovr_next;
   logic       w_tim_req;

   // Synchronizers, request latches and registered request outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_nmi_s1   <= 1'b1;
         r_nmi_s2   <= 1'b1;
         r_nmi_s3   <= 1'b1;
         r_irq_s1   <= 1'b1;
         r_irq_s2   <= 1'b1;
         r_live     <= 2'b00;
         r_nmi_arm  <= 1'b0;
         r_nmi      <= 1'b0;
         r_nmi_ovr  <= 1'b0;
         r_irq      <= 1'b0;
         r_irq2_tim <= 1'b0;
         r_irq2_sci <= 1'b0;
      end else begin
         r_nmi_s1   <= bus.NMI_N;
         r_nmi_s2   <= r_nmi_s1;
         r_nmi_s3   <= r_nmi_s2;
         r_irq_s1   <= bus.IRQ1_N;
         r_irq_s2   <= r_irq_s1;
         r_live     <= {r_live[0], 1'b1};
         r_nmi_arm  <= w_arm_next;
         r_nmi      <= w_nmi_next;
         r_nmi_ovr  <= w_ovr_next;
         r_irq      <= ~r_irq_s2;
         r_irq2_tim <= w_tim_req;
         r_irq2_sci <= bus.SCI_IRQ;
      end
   end

   // The reset-loaded 1s in the NMI chain are not real pin history, so edge
   // detection stays disarmed until a genuine high has reached s2.
   always_comb begin
      w_nmi_ack  = 1'b0;
      w_arm_next = r_nmi_arm;
      w_nmi_edge = 1'b0;
      w_nmi_next = r_nmi;
      w_ovr_next = r_nmi_ovr;
      w_tim_req  = 1'b0;

      w_nmi_ack  = bus.VFETCH & (bus.VADDR == VEC_NMI);
      w_arm_next = r_nmi_arm | (r_live[1] & r_nmi_s2);
      w_nmi_edge = r_nmi_arm & r_nmi_s3 & ~r_nmi_s2;
      w_nmi_next = w_nmi_edge | (r_nmi & ~w_nmi_ack);
      w_ovr_next = (w_nmi_edge & r_nmi & ~w_nmi_ack) | (r_nmi_ovr & ~bus.OVR_CLR);
      w_tim_req  = (bus.TIM_ICF & bus.TIM_EICI)
                 | (bus.TIM_OCF & bus.TIM_EOCI)
                 | (bus.TIM_TOF & bus.TIM_ETOI);
   end

   assign bus.NMI      = r_nmi;
   assign bus.NMI_OVR  = r_nmi_ovr;
   assign bus.IRQ      = r_irq;
   assign bus.IRQ2_TIM = r_irq2_tim;
   assign bus.IRQ2_SCI = r_irq2_sci;
   assign bus.WAKE     = r_nmi | r_irq | r_irq2_tim | r_irq2_sci;

endmodule

// File: tb/tb_hd63701_intc.sv
// Self-checking bench for hd63701_intc: directed sequences, a vector table for
// timer/SCI requests, and randomized traffic against a pin-history reference model.
module tb_hd63701_intc;

   typedef struct packed {
      logic       rst;
      logic       nmi_n;
      logic       irq1_n;
      logic       vfetch;
      logic [7:0] vaddr;
      logic       ovr_clr;
      logic       icf;
      logic       ocf;
      logic       tof;
      logic       eici;
      logic       eoci;
      logic       etoi;
      logic       sci;
   } stim_t;

   typedef struct {
      stim_t s;
      logic  e_tim;
      logic  e_sci;
   } vec_t;

   localparam int HMAX  = 8192;
   localparam int NVEC  = 10;
   localparam int NRAND = 3000;

   logic CLK = 1'b0;
   logic RST;
   hd63701_intc_if bus ();

   hd63701_intc dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int    checks   = 0;
   int    failures = 0;
   int    m        = 0;
   bit    cur_rst  = 1'b1;
   stim_t hist [HMAX];
   vec_t  vecs [NVEC];
   bit    e_nmi, e_ovr, e_irq, e_tim, e_sci;

   function automatic stim_t idle();
      stim_t s;
      s        = '0;
      s.nmi_n  = 1'b1;
      s.irq1_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t nlow();
      stim_t s;
      s       = idle();
      s.nmi_n = 1'b0;
      return s;
   endfunction

   function automatic stim_t mk_tim(input logic icf, ocf, tof, eici, eoci, etoi, sci);
      stim_t s;
      s      = idle();
      s.icf  = icf;  s.ocf  = ocf;  s.tof  = tof;
      s.eici = eici; s.eoci = eoci; s.etoi = etoi;
      s.sci  = sci;
      return s;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t cyc=%0d got=%b want=%b", name, $time, m, act, exp);
      end
   endtask

   task automatic apply(input stim_t s);
      RST          = s.rst;
      bus.NMI_N    = s.nmi_n;
      bus.IRQ1_N   = s.irq1_n;
      bus.VFETCH   = s.vfetch;
      bus.VADDR    = s.vaddr;
      bus.OVR_CLR  = s.ovr_clr;
      bus.TIM_ICF  = s.icf;
      bus.TIM_OCF  = s.ocf;
      bus.TIM_TOF  = s.tof;
      bus.TIM_EICI = s.eici;
      bus.TIM_EOCI = s.eoci;
      bus.TIM_ETOI = s.etoi;
      bus.SCI_IRQ  = s.sci;
      cur_rst      = s.rst;
      if (!s.rst && m < HMAX) hist[m] = s;
   endtask

   // Reference: NMI fires 3 cycles after a post-reset high->low pin transition,
   // retires on a $FC fetch; IRQ is the pin level 3 cycles late; TIM/SCI 1 cycle late.
   task automatic model_step();
      int n;
      bit ev, fc;
      if (cur_rst) begin
         m = 0;
         e_nmi = 0; e_ovr = 0; e_irq = 0; e_tim = 0; e_sci = 0;
      end else begin
         n = m;
         m = m + 1;
         ev = (n >= 3) && hist[n-3].nmi_n && !hist[n-2].nmi_n;
         fc = hist[n].vfetch && (hist[n].vaddr == 8'hFC);
         e_ovr = (ev && e_nmi && !fc) || (e_ovr && !hist[n].ovr_clr);
         e_nmi = ev || (e_nmi && !fc);
         e_irq = (m >= 3) ? !hist[m-3].irq1_n : 1'b0;
         e_tim = (hist[n].icf && hist[n].eici) || (hist[n].ocf && hist[n].eoci)
              || (hist[n].tof && hist[n].etoi);
         e_sci = hist[n].sci;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      model_step();
      check("model_NMI",      bus.NMI,      e_nmi);
      check("model_NMI_OVR",  bus.NMI_OVR,  e_ovr);
      check("model_IRQ",      bus.IRQ,      e_irq);
      check("model_IRQ2_TIM", bus.IRQ2_TIM, e_tim);
      check("model_IRQ2_SCI", bus.IRQ2_SCI, e_sci);
      check("model_WAKE",     bus.WAKE,     e_nmi | e_irq | e_tim | e_sci);
   endtask

   task automatic run(input stim_t s, input int n);
      for (int i = 0; i < n; i++) begin
         apply(s);
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      bit    rn, ri;

      vecs[0] = '{mk_tim(0,1,0, 0,0,0, 0), 1'b0, 1'b0};
      vecs[1] = '{mk_tim(0,1,0, 0,1,0, 0), 1'b1, 1'b0};
      vecs[2] = '{mk_tim(0,1,0, 0,1,0, 0), 1'b1, 1'b0};
      vecs[3] = '{mk_tim(0,0,0, 0,1,0, 0), 1'b0, 1'b0};
      vecs[4] = '{mk_tim(1,0,0, 1,0,0, 0), 1'b1, 1'b0};
      vecs[5] = '{mk_tim(0,0,1, 1,1,0, 0), 1'b0, 1'b0};
      vecs[6] = '{mk_tim(0,0,1, 0,0,1, 0), 1'b1, 1'b0};
      vecs[7] = '{mk_tim(1,1,1, 0,0,0, 1), 1'b0, 1'b1};
      vecs[8] = '{mk_tim(1,1,1, 1,1,1, 1), 1'b1, 1'b1};
      vecs[9] = '{mk_tim(0,0,0, 0,0,0, 0), 1'b0, 1'b0};

      // Reset state
      s = idle(); s.rst = 1'b1;
      run(s, 2);
      check("rst_NMI", bus.NMI, 1'b0);
      check("rst_OVR", bus.NMI_OVR, 1'b0);
      check("rst_WAKE", bus.WAKE, 1'b0);
      run(idle(), 5);

      // NMI fall, 3-cycle latency, retire on $FC fetch at cycle 10, held low = one request
      apply(nlow()); tick();
      for (int c = 1; c <= 12; c++) begin
         check("seqA_NMI", bus.NMI, logic'(c >= 3 && c <= 10));
         s = nlow();
         if (c == 10) begin s.vfetch = 1'b1; s.vaddr = 8'hFC; end
         apply(s); tick();
      end

      // Non-$FC fetch keeps NMI; second edge sets overrun; OVR_CLR clears it
      run(idle(), 3);
      run(nlow(), 3);
      check("seqB_NMI_set", bus.NMI, 1'b1);
      check("seqB_OVR_quiet", bus.NMI_OVR, 1'b0);
      s = nlow(); s.vfetch = 1'b1; s.vaddr = 8'hF8;
      apply(s); tick();
      check("seqB_F8_keeps", bus.NMI, 1'b1);
      run(idle(), 2);
      run(nlow(), 3);
      check("seqB_OVR_set", bus.NMI_OVR, 1'b1);
      check("seqB_NMI_single", bus.NMI, 1'b1);
      s = nlow(); s.ovr_clr = 1'b1;
      apply(s); tick();
      check("seqB_OVR_clr", bus.NMI_OVR, 1'b0);

      // Edge coinciding with $FC fetch: set wins, no overrun (pending and idle cases)
      run(idle(), 2);
      run(nlow(), 2);
      s = nlow(); s.vfetch = 1'b1; s.vaddr = 8'hFC;
      apply(s); tick();
      check("seqC_set_wins", bus.NMI, 1'b1);
      check("seqC_no_ovr", bus.NMI_OVR, 1'b0);
      apply(s); tick();
      check("seqC_ack", bus.NMI, 1'b0);
      run(idle(), 2);
      run(nlow(), 2);
      apply(s); tick();
      check("seqC_set_wins2", bus.NMI, 1'b1);
      check("seqC_no_ovr2", bus.NMI_OVR, 1'b0);

      // Overrun coinciding with OVR_CLR: set wins
      run(idle(), 2);
      run(nlow(), 2);
      s = nlow(); s.ovr_clr = 1'b1;
      apply(s); tick();
      check("seqC_ovr_set_wins", bus.NMI_OVR, 1'b1);
      apply(s); tick();
      check("seqC_ovr_clr", bus.NMI_OVR, 1'b0);

      // NMI_N low through reset: no request until high >= 2 then low
      s = nlow(); s.rst = 1'b1;
      run(s, 2);
      for (int i = 0; i < 6; i++) begin
         apply(nlow()); tick();
         check("seqD_held_low", bus.NMI, 1'b0);
      end
      run(idle(), 2);
      run(nlow(), 2);
      check("seqD_before", bus.NMI, 1'b0);
      apply(nlow()); tick();
      check("seqD_fires", bus.NMI, 1'b1);

      // Reset drops pending NMI and discards an in-flight edge
      run(idle(), 2);
      apply(nlow()); tick();
      s = idle(); s.rst = 1'b1;
      apply(s); tick();
      check("seqE_rst_NMI", bus.NMI, 1'b0);
      check("seqE_rst_OVR", bus.NMI_OVR, 1'b0);
      for (int i = 0; i < 6; i++) begin
         apply(idle()); tick();
         check("seqE_no_ghost", bus.NMI, 1'b0);
      end

      // IRQ1_N low 5 cycles -> IRQ high 5 cycles, 3 late, not shortened by fetch
      s = idle(); s.irq1_n = 1'b0;
      apply(s); tick();
      for (int c = 1; c <= 10; c++) begin
         check("seqF_IRQ", bus.IRQ, logic'(c >= 3 && c <= 7));
         s = idle();
         s.irq1_n = (c < 5) ? 1'b0 : 1'b1;
         if (c == 4) begin s.vfetch = 1'b1; s.vaddr = 8'hF8; end
         apply(s); tick();
      end

      // Timer/SCI request table: expectation one cycle after each row
      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i].s); tick();
         check("vec_IRQ2_TIM", bus.IRQ2_TIM, vecs[i].e_tim);
         check("vec_IRQ2_SCI", bus.IRQ2_SCI, vecs[i].e_sci);
         check("vec_WAKE", bus.WAKE, vecs[i].e_tim | vecs[i].e_sci);
      end

      // Randomized traffic against the reference model
      rn = 1'b1;
      ri = 1'b1;
      for (int i = 0; i < NRAND; i++) begin
         if ($urandom_range(0, 3) == 0) rn = ~rn;
         if ($urandom_range(0, 4) == 0) ri = ~ri;
         s         = '0;
         s.nmi_n   = rn;
         s.irq1_n  = ri;
         s.rst     = ($urandom_range(0, 299) == 0);
         s.vfetch  = ($urandom_range(0, 5) == 0);
         s.vaddr   = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'(8'hF0 + 2 * $urandom_range(0, 7));
         s.ovr_clr = ($urandom_range(0, 9) == 0);
         s.icf     = 1'($urandom_range(0, 1));
         s.ocf     = 1'($urandom_range(0, 1));
         s.tof     = 1'($urandom_range(0, 1));
         s.eici    = 1'($urandom_range(0, 1));
         s.eoci    = 1'($urandom_range(0, 1));
         s.etoi    = 1'($urandom_range(0, 1));
         s.sci     = 1'($urandom_range(0, 1));
         apply(s); tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
